// File: rtl/rr_arb8_if.sv
// rr_arb8_if: request/grant bundle between the requesters (master) and the
// 8-way round-robin arbiter (slave).
interface rr_arb8_if;
  logic [7:0] Req;
  logic       Done;
  logic [7:0] Gnt;
  logic [2:0] GntIdx;
  logic       GntValid;
  logic       Timeout;

  // Requester side: drives requests and release, observes the grant.
  modport master (
    output Req,
    output Done,
    input  Gnt,
    input  GntIdx,
    input  GntValid,
    input  Timeout
  );

  // Arbiter side: observes requests and release, drives the grant.
  modport slave (
    input  Req,
    input  Done,
    output Gnt,
    output GntIdx,
    output GntValid,
    output Timeout
  );
endinterface

// File: rtl/rr_arb8.sv
// rr_arb8: 8-requester round-robin arbiter with a two-state IDLE/OWNED FSM.
// A grant is held until the owner pulses Done or drops its request; the
// search pointer then moves past the owner, and one idle cycle always
// separates consecutive grants.
// Optional feature macro: RR_ARB8_TIMEOUT_EN adds a hold counter that
// force-releases a grant after TIMEOUT_CYCLES cycles and pulses Timeout.
module rr_arb8 #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       Clk,
  input  logic       Rst,
  rr_arb8_if.slave   bus
);

  localparam int unsigned N     = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  logic             found_c;
  logic [IDX_W-1:0] pick_c;
  logic [IDX_W-1:0] cand_c;
  logic             release_c;
  logic             expire_c;

  // A zero hold limit has no meaningful behaviour; reject it at elaboration.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("rr_arb8: TIMEOUT_CYCLES must be at least 1");
  end

  // First set request searching upward from ptr_q with wrap-around.
  always_comb begin
    found_c = 1'b0;
    pick_c  = ptr_q;
    cand_c  = ptr_q;
    for (int unsigned i = 0; i < N; i++) begin
      cand_c = ptr_q + IDX_W'(i);
      if (!found_c && bus.Req[cand_c]) begin
        found_c = 1'b1;
        pick_c  = cand_c;
      end
    end
  end

  assign release_c = bus.Done || !bus.Req[gnt_idx_q];

`ifdef RR_ARB8_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  assign expire_c = (hold_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Hold counter: zero on entry to OWNED, counts every cycle the grant stays.
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == OWNED && state_d == OWNED) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
  end

  // Hold counter register.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign expire_c = 1'b0;
`endif

  // Next-state and registered-output logic; a normal release beats expiry.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d     = OWNED;
          gnt_idx_d   = pick_c;
          gnt_d       = N'(1) << pick_c;
          gnt_valid_d = 1'b1;
        end
      end
      OWNED: begin
        if (release_c || expire_c) begin
          state_d     = IDLE;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          gnt_idx_d   = '0;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          timeout_d   = !release_c && expire_c;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_idx_d   = '0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers, cleared asynchronously by Rst.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.Gnt      = gnt_q;
  assign bus.GntIdx   = gnt_idx_q;
  assign bus.GntValid = gnt_valid_q;
  assign bus.Timeout  = timeout_q;

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16; number of cycles a grant may be held before forced release (used only with RR_ARB8_TIMEOUT_EN).
REQ-002 Port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port Rst  input  1  reset, asynchronous and active-high.
REQ-004 Port Req  input  8  per-requester request, bit i = requester i; level-sensitive.
REQ-005 Port Done  input  1  owner releases the resource this cycle; ignored when no grant is active.
REQ-006 Port Gnt  output  8  registered one-hot grant, all-zero when idle.
REQ-007 Port GntIdx  output  3  registered binary index of the owner; 0 when idle.
REQ-008 Port GntValid  output  1  registered; high while any grant is active.
REQ-009 Port Timeout  output  1  registered one-cycle pulse when a grant is force-released; constant 0 when the feature is compiled out.

Function
REQ-010 The FSM SHALL have exactly two states, IDLE and OWNED.
REQ-011 In IDLE with Req nonzero, the arbiter SHALL select the first set Req bit searching upward from Ptr with wrap (Ptr, Ptr+1, ... 7, 0, ... Ptr-1), then enter OWNED on the next edge.
REQ-012 Grant latency SHALL be exactly one cycle from Req sampled in IDLE to Gnt/GntIdx/GntValid asserted.
REQ-013 Gnt SHALL always equal the one-hot decode of GntIdx when GntValid=1, and SHALL be zero otherwise.
REQ-014 In OWNED, the grant SHALL be held unchanged regardless of Req until release.
REQ-015 Release SHALL occur on an edge where Done=1, or where Req[GntIdx]=0 (owner drops its request).
REQ-016 On release, Ptr SHALL become GntIdx+1 modulo 8 (7 wraps to 0), and the FSM SHALL return to IDLE with Gnt zero for at least one cycle (no back-to-back grant).
REQ-017 Done and owner Req drop in the same cycle SHALL cause a single release.
REQ-018 Done in IDLE SHALL have no effect on state, Ptr, or outputs.
REQ-019 Requests of non-owners SHALL never alter Gnt during OWNED.
REQ-020 Under continuous Req=8'hFF, grants SHALL rotate 0,1,2,...,7,0 with no requester starved.

Reset
REQ-021 Rst=1 SHALL immediately force state IDLE, Ptr=0, Gnt=0, GntIdx=0, GntValid=0, Timeout=0, and the hold counter to 0, independent of Clk.
REQ-022 Reset asserted during OWNED SHALL drop the grant without a Timeout pulse; the first grant after deassertion starts the search at requester 0.

Configuration
REQ-023 Macro RR_ARB8_TIMEOUT_EN SHALL compile in a hold counter that clears on entry to OWNED and increments each OWNED cycle.
REQ-024 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 without a release, the next edge SHALL release as in REQ-016 and pulse Timeout for one cycle.
REQ-025 With the macro defined, a normal release on the same edge as timeout expiry SHALL take priority: no Timeout pulse.
REQ-026 Without the macro, no counter SHALL exist, Timeout SHALL be tied 0, and grants SHALL be held indefinitely.

Verification
REQ-027 Reset then Req=8'h00 for 10 cycles -> Gnt=0, GntValid=0, GntIdx=0 throughout.
REQ-028 Req=8'h24 from IDLE, Ptr=0 -> one cycle later Gnt=8'h04, GntIdx=2; Done pulse -> next cycle Gnt=0; following grant Gnt=8'h20, GntIdx=5.
REQ-029 Req=8'hFF held, Done pulsed one cycle after each grant -> GntIdx sequence 0..7,0 with one idle cycle between grants.
REQ-030 Grant to requester 7, then release -> Ptr wraps; with Req=8'h81, next grant is requester 0.
REQ-031 Rst asserted mid-grant at GntIdx=3 -> outputs zero asynchronously; after release of Rst with Req=8'h0A, grant goes to requester 1.
REQ-032 RR_ARB8_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, Req=8'h01 held, Done=0 -> Gnt=8'h01 for 16 cycles, then Gnt=0 with Timeout=1 for one cycle; macro undefined -> grant held, Timeout stays 0.
